// File: rtl/ram_ctrl_pkg.sv
// Shared types for the ram_ctrl request front-end: FSM state encoding,
// the queued request record and the default widths that size it.
package ram_ctrl_pkg;

   localparam int ADDR_W     = 13;
   localparam int DATA_W     = 8;
   localparam int LEN_W      = 4;
   localparam int FIFO_DEPTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RSP  = 2'd3
   } state_t;

   // Field widths are fixed here; the top-level width parameters must agree.
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
      logic [LEN_W-1:0]  len;
   } req_t;

endpackage

// File: rtl/ram_ctrl_fifo.sv
// Synchronous request FIFO of req_t entries. Pointers carry one extra wrap
// bit so full and empty are distinguished without a separate counter.
module ram_ctrl_fifo
   import ram_ctrl_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic push,
   input  req_t din,
   input  logic pop,
   output req_t dout,
   output logic full,
   output logic empty
);

   localparam int PW = $clog2(DEPTH);

   req_t        mem_q [DEPTH];
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic        push_en;
   logic        pop_en;

   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                    (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
   assign push_en = push && !full;
   assign pop_en  = pop && !empty;
   assign dout    = mem_q[rd_ptr_q[PW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_en) wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, 1'b1};
      if (pop_en)  rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q[PW-1:0]] <= din;
   end

endmodule

// File: rtl/ram_ctrl.sv
// Request front-end for an 8-bit x 8K single-port RAM: FIFO, strobe FSM and
// read-response register. Define RAM_CTRL_BURST_EN to enable multi-beat reads.
module ram_ctrl
   import ram_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_W,
   parameter int DATA_WIDTH = DATA_W,
   parameter int FIFO_DEPTH = ram_ctrl_pkg::FIFO_DEPTH,
   parameter int LEN_WIDTH  = LEN_W
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_last,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wdata_oe,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  busy
);

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [LEN_WIDTH-1:0]  beats_q, beats_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  last_q,  last_d;

   req_t                  fifo_din;
   req_t                  fifo_dout;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [LEN_WIDTH-1:0]  first_beats;

   always_comb begin
      fifo_din.we    = req_we;
      fifo_din.addr  = req_addr;
      fifo_din.wdata = req_wdata;
      fifo_din.len   = req_len;
   end

   ram_ctrl_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (req_valid),
      .din   (fifo_din),
      .pop   (fifo_pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Extra beats remaining after the first; writes are always a single beat.
`ifdef RAM_CTRL_BURST_EN
   assign first_beats = fifo_dout.we ? '0 : fifo_dout.len;
`else
   logic unused_len;
   assign unused_len  = ^fifo_dout.len;
   assign first_beats = '0;
`endif

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      beats_d  = beats_q;
      rdata_d  = rdata_q;
      last_d   = last_q;
      fifo_pop = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               addr_d   = fifo_dout.addr;
               wdata_d  = fifo_dout.wdata;
               beats_d  = first_beats;
               state_d  = fifo_dout.we ? WR : RD;
            end
         end
         WR: begin
            state_d = IDLE;
         end
         RD: begin
            rdata_d = mem_rdata;
            last_d  = (beats_q == '0);
            state_d = RSP;
         end
         RSP: begin
            // A stalled consumer holds the FSM here; the FIFO keeps accepting.
            if (rsp_ready) begin
               if (beats_q != '0) begin
                  beats_d = beats_q - {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                  addr_d  = addr_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
                  state_d = RD;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         beats_q <= '0;
         rdata_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         beats_q <= beats_d;
         rdata_q <= rdata_d;
         last_q  <= last_d;
      end
   end

   // Strobes come straight from the state flops, so reset drops them at once.
   assign mem_cs       = (state_q == WR) || (state_q == RD);
   assign mem_we       = (state_q == WR);
   assign mem_oe       = (state_q == RD);
   assign mem_wdata_oe = (state_q == WR);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;

   assign rsp_valid    = (state_q == RSP);
   assign rsp_rdata    = rdata_q;
   assign rsp_last     = (state_q == RSP) && last_q;

   assign req_ready    = !fifo_full;
   assign busy         = (state_q != IDLE) || !fifo_empty;

endmodule
